gray_step_monitor: RTL and testbench

GRAY_STEP_MONITOR -- requirements
Module: gray_step_monitor

---
 rtl/gray_step_monitor.sv | 165 ++++++++++++++++
 tb/tb_gray_step_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_monitor.sv
// ---------------------------------------------------------------------------
// gray_step_monitor
//
// Watches the output of an N-bit Gray-code counter and checks that every
// count step is a legal single-bit move to the next code. It also catches
// glitches, which are changes on gray_in outside a sample cycle.
// The first sample after reset is taken as the reference without a check.
// After that, each sample is checked against the last accepted value.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-low reset
//   step        counter enable pulse; sampled into step_d
//   gray_in     Gray value from the counter (N bits)
//   clear_err   level request to clear the sticky err flag (FAULT only)
//   bin_out     binary value of the last accepted Gray sample
//   valid       a reference sample has been captured
//   err         sticky sequence-error flag
//   err_count   saturating count of detected errors (CW bits)
//   wrap        one-cycle pulse on a good step from 2^N-1 to 0
//   wrap_count  saturating count of wrap events (CW bits)
// ---------------------------------------------------------------------------
module gray_step_monitor #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic [N-1:0]  gray_in,
    input  logic          clear_err,
    output logic [N-1:0]  bin_out,
    output logic          valid,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic          wrap,
    output logic [CW-1:0] wrap_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [N-1:0]  BIN_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  BIN_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t          state_reg;
    state_t          state_next;
    logic            step_d_reg;
    logic [N-1:0]    prev_g_reg;
    logic [N-1:0]    prev_b_reg;
    logic            valid_reg;
    logic            err_reg;
    logic [CW-1:0]   err_count_reg;
    logic            wrap_reg;
    logic [CW-1:0]   wrap_count_reg;

    logic [N-1:0]    bin_conv;
    logic [N-1:0]    diff;
    logic [N-1:0]    prev_b_inc;
    logic            one_bit_change;
    logic            good_step;
    logic            err_event;

    // Control actions decoded from the state and the current cycle.
    logic            capture;
    logic            clr_err;
    logic            wrap_hit;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above
    // it. This is the b[i] = b[i+1] ^ g[i] chain written without feedback.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_conv
            assign bin_conv[gi] = ^gray_in[N-1:gi];
        end
    endgenerate

    assign diff           = gray_in ^ prev_g_reg;
    assign one_bit_change = (diff != '0) && ((diff & (diff - BIN_ONE)) == '0);
    assign prev_b_inc     = prev_b_reg + BIN_ONE;
    assign good_step      = one_bit_change && (bin_conv == prev_b_inc);

    // A sample cycle is judged on the step itself. Any other cycle is a
    // glitch if gray_in has moved away from the reference.
    assign err_event = (state_reg != IDLE) &&
                       (step_d_reg ? !good_step : (gray_in != prev_g_reg));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (step_d_reg)             state_next = TRACK;
            TRACK:   if (err_event)              state_next = FAULT;
            FAULT:   if (!err_event && clear_err) state_next = TRACK;
            default:                             state_next = IDLE;
        endcase
    end

    // Output / action decode
    always_comb begin
        // Every sample cycle moves the reference, including a bad step.
        capture  = step_d_reg;
        // A detected error takes priority over a clear request.
        clr_err  = (state_reg == FAULT) && clear_err && !err_event;
        wrap_hit = (state_reg != IDLE) && step_d_reg && good_step &&
                   (prev_b_reg == BIN_MAX);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_d_reg     <= 1'b0;
            prev_g_reg     <= '0;
            prev_b_reg     <= '0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
            err_count_reg  <= '0;
            wrap_reg       <= 1'b0;
            wrap_count_reg <= '0;
        end else begin
            step_d_reg <= step;
            wrap_reg   <= wrap_hit;

            if (capture) begin
                prev_g_reg <= gray_in;
                prev_b_reg <= bin_conv;
                valid_reg  <= 1'b1;
            end

            if (err_event) begin
                err_reg <= 1'b1;
                if (err_count_reg != CNT_MAX) begin
                    err_count_reg <= err_count_reg + CNT_ONE;
                end
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end

            if (wrap_hit && (wrap_count_reg != CNT_MAX)) begin
                wrap_count_reg <= wrap_count_reg + CNT_ONE;
            end
        end
    end

    assign bin_out    = prev_b_reg;
    assign valid      = valid_reg;
    assign err        = err_reg;
    assign err_count  = err_count_reg;
    assign wrap       = wrap_reg;
    assign wrap_count = wrap_count_reg;

endmodule

// File: tb/tb_gray_step_monitor.sv
// ---------------------------------------------------------------------------
// tb_gray_step_monitor
//
// Directed scenarios followed by randomized traffic. A behavioural model
// checks all of it, cycle by cycle. The model keeps only the accepted Gray
// value and a coarse mode. It derives binary values and step legality with
// plain arithmetic.
// ---------------------------------------------------------------------------
module tb_gray_step_monitor;

    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int MOD = 2 ** N;
    localparam int SAT = 2 ** CW - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          step = 1'b0;
    logic [N-1:0]  gray_in = '0;
    logic          clear_err = 1'b0;
    logic [N-1:0]  bin_out;
    logic          valid;
    logic          err;
    logic [CW-1:0] err_count;
    logic          wrap;
    logic [CW-1:0] wrap_count;

    always #5 clk = ~clk;

    gray_step_monitor #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .gray_in    (gray_in),
        .clear_err  (clear_err),
        .bin_out    (bin_out),
        .valid      (valid),
        .err        (err),
        .err_count  (err_count),
        .wrap       (wrap),
        .wrap_count (wrap_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 = no reference yet, 1 = tracking, 2 = faulted
    int           m_mode = 0;
    int           m_step_d = 0;
    logic [N-1:0] m_ref = '0;
    int           m_valid = 0;
    int           m_err = 0;
    int           m_errc = 0;
    int           m_wrap = 0;
    int           m_wrapc = 0;

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < N; s++) b = b ^ (g >> s);
        return b % MOD;
    endfunction

    function automatic logic [N-1:0] b2g(input int b);
        int bm;
        bm = b % MOD;
        return N'((bm ^ (bm >> 1)));
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int  s;
        bit  ev;
        if (!reset) begin
            m_mode = 0; m_step_d = 0; m_ref = '0; m_valid = 0;
            m_err = 0; m_errc = 0; m_wrap = 0; m_wrapc = 0;
        end else begin
            s = m_step_d;
            m_step_d = int'(step);
            m_wrap = 0;
            ev = 0;
            if (m_mode == 0) begin
                if (s != 0) begin
                    m_ref = gray_in;
                    m_valid = 1;
                    m_mode = 1;
                end
            end else begin
                if (s != 0) begin
                    if ($countones(gray_in ^ m_ref) == 1 &&
                        g2b(int'(gray_in)) == (g2b(int'(m_ref)) + 1) % MOD) begin
                        if (g2b(int'(m_ref)) == MOD - 1) begin
                            m_wrap = 1;
                            if (m_wrapc < SAT) m_wrapc++;
                        end
                    end else begin
                        ev = 1;
                    end
                    m_ref = gray_in;
                end else if (gray_in != m_ref) begin
                    ev = 1;
                end
                if (ev) begin
                    m_err = 1;
                    if (m_errc < SAT) m_errc++;
                    m_mode = 2;
                end else if (m_mode == 2 && clear_err) begin
                    m_err = 0;
                    m_mode = 1;
                end
            end
        end
    endtask

    // One clock: update the model, take the edge, then compare all outputs.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("bin_out", bin_out, g2b(int'(m_ref)));
        check("valid", valid, m_valid);
        check("err", err, m_err);
        check("err_count", err_count, m_errc);
        check("wrap", wrap, m_wrap);
        check("wrap_count", wrap_count, m_wrapc);
    endtask

    // Pulse step for one cycle. The counter output changes on that edge, so
    // the following cycle is the sample cycle.
    task automatic pulse_step(input logic [N-1:0] next_g);
        step = 1'b1;
        cycle();
        step = 1'b0;
        gray_in = next_g;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step = 1'b0;
        clear_err = 1'b0;
        gray_in = '0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        int wraps;
        bit step_was;
        int r;

        // Reset state
        reset = 1'b0;
        cycle();
        cycle();
        check("rst_bin_out", bin_out, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_wrap", wrap, 0);
        check("rst_wrap_count", wrap_count, 0);
        reset = 1'b1;
        cycle();
        check("idle_valid", valid, 0);

        // Twenty clean steps starting at 0000
        wraps = 0;
        pulse_step(b2g(0));
        check("first_valid", valid, 1);
        check("first_bin", bin_out, 0);
        for (int k = 1; k < 20; k++) begin
            pulse_step(b2g(k));
            wraps += int'(wrap);
            check("clean_bin", bin_out, k % MOD);
        end
        check("clean_err", err, 0);
        check("clean_wrap_count", wrap_count, 1);
        check("clean_wrap_pulses", wraps, 1);

        // Skip from 0001 to 0010, then a good step 0010 -> 0110
        do_reset();
        pulse_step(4'b0000);
        pulse_step(4'b0001);
        pulse_step(4'b0010);
        check("skip_err", err, 1);
        check("skip_err_count", err_count, 1);
        check("skip_bin", bin_out, 3);
        pulse_step(4'b0110);
        check("after_skip_err", err, 1);
        check("after_skip_bin", bin_out, 4);

        // Clear without an error, then a clear that coincides with a bad step
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        check("clear_err_low", err, 0);
        check("clear_count_kept", err_count, 1);
        step = 1'b1;
        cycle();
        step = 1'b0;
        gray_in = 4'b0000;
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        check("clear_vs_err", err, 1);
        check("clear_vs_err_count", err_count, 2);
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        check("clear_again", err, 0);

        // Two glitch cycles on a held value of 0011
        do_reset();
        pulse_step(4'b0000);
        pulse_step(4'b0001);
        pulse_step(4'b0011);
        gray_in = 4'b0111;
        cycle();
        cycle();
        gray_in = 4'b0011;
        cycle();
        check("glitch_count", err_count, 2);
        check("glitch_bin", bin_out, 2);
        pulse_step(4'b0010);
        check("glitch_ref_kept", err_count, 2);
        check("glitch_next_bin", bin_out, 3);

        // Saturation of err_count
        do_reset();
        pulse_step(4'b0000);
        gray_in = 4'b1111;
        repeat (260) cycle();
        check("sat_err_count", err_count, SAT);
        gray_in = 4'b0000;
        cycle();

        // Reset mid-count, then recapture a non-consecutive value
        do_reset();
        pulse_step(b2g(0));
        for (int k = 1; k <= 9; k++) pulse_step(b2g(k));
        check("mid_bin", bin_out, 9);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check("mid_rst_bin", bin_out, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_wrap_count", wrap_count, 0);
        pulse_step(b2g(13));
        check("recap_valid", valid, 1);
        check("recap_err", err, 0);
        check("recap_bin", bin_out, 13);

        // Randomized traffic driven by a counter with occasional faults
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 99);
            reset = (r < 2) ? 1'b0 : 1'b1;
            step = ($urandom_range(0, 3) == 0);
            clear_err = ($urandom_range(0, 9) == 0);
            step_was = step;
            cycle();
            r = $urandom_range(0, 99);
            if (step_was) begin
                if (r < 85) gray_in = b2g(g2b(int'(gray_in)) + 1);
                else        gray_in = N'($urandom);
            end else if (r < 4) begin
                gray_in = N'($urandom);
            end
        end
        reset = 1'b1;
        step = 1'b0;
        clear_err = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
